wc_tile_buffer: RTL and testbench
=================================

# wc_tile_buffer

- Upstream input stage of the Winograd F(3,3) core `WC`.
- Accepts a serial stream of 10-bit samples, one per handshake.
- Assembles them into overlapping 5-sample input tiles: stride 3, overlap 2.
- Presents each tile as a 50-bit word, in exactly the form `WC` consumes on its `D` input, under a valid/ready handshake.

## Interface
Parameters:
- DW, 10, sample width in bits
- TILE, 5, samples per tile (Winograd input tile)
- M, 3, new samples per subsequent tile (Winograd output count)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  DW  sample
- in_last  in  1  sample is the final one of a row
- tile_valid  out  1  tile present
- tile_ready  in  1  downstream accepts the tile when tile_valid && tile_ready
- tile_data  out  DW*TILE  tile; slice [DW*i +: DW] = window entry i, entry 0 oldest
- tile_last  out  1  tile contains the final sample of its row

## Operation
- Window: 5-entry shift register `win[0..4]` plus `fill` (0..5) giving the number of valid top entries.
- Each accepted sample performs win[i]<=win[i+1] and win[4]<=in_data, then fill+1.
- Output register: tile_data, tile_valid, tile_last.
- slot_free = !tile_valid || tile_ready.
- State FILL (fill<5):
  - in_ready=1.
  - When an accept brings fill to 5, go to EMIT.
- State EMIT (fill==5):
  - If slot_free: tile_data<=win, tile_valid<=1, tile_last<=row_end.
  - If row_end: fill<=0, row_end<=0.
  - Otherwise fill<=2 (overlap retained), or fill<=3 if a sample is accepted in the same cycle.
  - in_ready = slot_free && !row_end.
- row_end flag: set when the accepted sample has in_last=1.
- Partial row (in_last accepted with resulting fill<5): behaviour per Configuration.
- A tile output is never overwritten while tile_valid && !tile_ready; tile_data and tile_last stay stable until the handshake.
- No overlap across rows: the first tile of every row needs 5 fresh samples.
- A row of 5+3k samples yields k+1 tiles, the last one with tile_last=1.

## Timing
- Reset (rst low at a clk edge): fill=0, row_end=0, tile_valid=0, tile_last=0, tile_data=0, state FILL. While rst is low, in_ready=0.
- Reset mid-operation discards the window and any pending tile.
- Latency: the sample completing a window is accepted at edge k; tile_valid rises at edge k+1 if the slot is free.
- Sustained throughput, with no backpressure inside a row: 1 sample/cycle, 1 tile per 3 cycles. in_ready stays high because EMIT accepts concurrently.
- Row boundary costs 1 bubble cycle (in_ready=0 during the EMIT with row_end).
- Simultaneous tile_ready and emit: the old tile retires and the new one loads in the same edge.

## Configuration
- Macro `WC_TILE_ZERO_PAD_EN`.
- Defined: partial row enters state PAD.
  - in_ready=0.
  - Zeros shift into win[4] one per cycle until fill==5.
  - Then EMIT with tile_last=1.
- Undefined: partial samples are dropped, fill<=0, no tile is emitted for them, and the cycle returns to FILL.

## Structure
- Shared package `wc_pkg`:
  - constants WC_DW=10, WC_TILE=5, WC_M=3, WC_OVL=2.
  - state enum {FILL, EMIT, PAD}.
- `WC` and this block both use the package.
- One sub-module: `wc_win_shift`, the 5-entry DW-bit shift register with shift-in enable and zero-fill input.
- The FSM, fill counter and output register stay in `wc_tile_buffer`.

## Test plan
- **Basic row:** reset, tile_ready=1, stream 1..8 with in_last on 8 → tiles {1,2,3,4,5} then {4,5,6,7,8} with tile_last=1 on the second only.
- **Backpressure:** tile_ready=0, stream 1..11 → tile {1..5} held stable; in_ready falls after sample 8 is accepted. Raise tile_ready → {4..8}, then {7..11}; no sample lost or duplicated.
- **Back-to-back rows:** two rows of 5 (1..5 last, 6..10 last) → {1..5} last and {6..10} last, with no overlap and exactly one bubble between rows.
- **Partial row:** samples 1..6, in_last on 6.
  - With WC_TILE_ZERO_PAD_EN: {1..5}, then {4,5,6,0,0} last.
  - Without: only {1..5}; the next row starts from fill=0.
- **Reset mid-operation:** after 7 samples with tile_ready=0, hold rst low for 1 cycle → tile_valid=0 and in_ready=0 during reset. Samples 20..24 then yield {20..24}.
- **Throughput:** continuous valid/ready, a row of 35 samples → 11 tiles in 36 cycles, in_ready never low inside the row.

Source files
------------

// File: rtl/wc_pkg.sv
// Shared constants and state encoding for the Winograd F(3,3) core and its input stage.
package wc_pkg;

  localparam int unsigned WC_DW   = 10;
  localparam int unsigned WC_TILE = 5;
  localparam int unsigned WC_M    = 3;
  localparam int unsigned WC_OVL  = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } wc_state_e;

endpackage

// File: rtl/wc_win_shift.sv
// Sliding sample window: entry 0 (LSB slice) is the oldest, new samples enter at the top entry.
module wc_win_shift
  import wc_pkg::*;
#(
  parameter int unsigned DW   = WC_DW,
  parameter int unsigned TILE = WC_TILE
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_en_i,
  input  logic               zero_fill_i,
  input  logic [DW-1:0]      data_i,
  output logic [DW*TILE-1:0] win_o
);

  logic [DW*TILE-1:0] win_q, win_d;
  logic [DW-1:0]      shift_in;

  assign shift_in = zero_fill_i ? '0 : data_i;

  always_comb begin
    win_d = win_q;
    if (shift_en_i) begin
      win_d = {shift_in, win_q[DW*TILE-1:DW]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/wc_tile_buffer.sv
// Serial-to-tile input stage for WC: builds overlapping 5-sample tiles (stride 3) per row.
// Optional build macro WC_TILE_ZERO_PAD_EN zero-pads a partial final tile instead of dropping it.
module wc_tile_buffer
  import wc_pkg::*;
#(
  parameter int unsigned DW   = WC_DW,
  parameter int unsigned TILE = WC_TILE,
  parameter int unsigned M    = WC_M
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               in_last,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic [DW*TILE-1:0] tile_data,
  output logic               tile_last
);

  localparam int unsigned   FW       = $clog2(TILE + 1);
  localparam logic [FW-1:0] FillFull = FW'(TILE);
  localparam logic [FW-1:0] FillOvl  = FW'(TILE - M);
  localparam logic [FW-1:0] FillOne  = FW'(1);

  wc_state_e state_q, state_d;

  logic [FW-1:0]      fill_q, fill_d;
  logic               row_end_q, row_end_d;
  logic               tile_valid_q;
  logic               tile_last_q;
  logic [DW*TILE-1:0] tile_data_q;

  logic               slot_free;
  logic               accept;
  logic               emit;
  logic               zero_fill;
  logic               shift_en;
  logic               partial;
  logic [DW*TILE-1:0] win;

  assign slot_free = !tile_valid_q || tile_ready;
  assign accept    = in_valid && in_ready;
  assign shift_en  = accept || zero_fill;

  wc_win_shift #(
    .DW  (DW),
    .TILE(TILE)
  ) u_win (
    .clk_i      (clk),
    .rst_ni     (rst),
    .shift_en_i (shift_en),
    .zero_fill_i(zero_fill),
    .data_i     (in_data),
    .win_o      (win)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, fill count and row-end tracking
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    row_end_d = row_end_q;
    partial   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          fill_d    = fill_q + FillOne;
          row_end_d = in_last;
          if (fill_d == FillFull) begin
            state_d = EMIT;
          end else begin
            partial = in_last;
          end
        end
      end
      EMIT: begin
        if (slot_free) begin
          if (row_end_q) begin
            state_d   = FILL;
            fill_d    = '0;
            row_end_d = 1'b0;
          end else begin
            // Overlap stays in the window; a concurrent accept extends it by one.
            state_d = FILL;
            fill_d  = accept ? FillOvl + FillOne : FillOvl;
            if (accept) begin
              row_end_d = in_last;
              if (fill_d == FillFull) begin
                state_d = EMIT;
              end else begin
                partial = in_last;
              end
            end
          end
        end
      end
      PAD: begin
        fill_d = fill_q + FillOne;
        if (fill_d == FillFull) begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    if (partial) begin
`ifdef WC_TILE_ZERO_PAD_EN
      state_d = PAD;
`else
      state_d   = FILL;
      fill_d    = '0;
      row_end_d = 1'b0;
`endif
    end
  end

  // Handshake and datapath control
  always_comb begin
    in_ready  = 1'b0;
    emit      = 1'b0;
    zero_fill = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = rst;
      end
      EMIT: begin
        in_ready = rst && slot_free && !row_end_q;
        emit     = slot_free;
      end
      PAD: begin
        zero_fill = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q       <= '0;
      row_end_q    <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;
      tile_data_q  <= '0;
    end else begin
      fill_q    <= fill_d;
      row_end_q <= row_end_d;
      // The window register still holds the pre-shift tile during a concurrent accept.
      if (emit) begin
        tile_valid_q <= 1'b1;
        tile_data_q  <= win;
        tile_last_q  <= row_end_q;
      end else if (tile_ready) begin
        tile_valid_q <= 1'b0;
      end
    end
  end

  assign tile_valid = tile_valid_q;
  assign tile_data  = tile_data_q;
  assign tile_last  = tile_last_q;

endmodule

// File: tb/tb_wc_tile_buffer.sv
// Self-checking bench for wc_tile_buffer: row table plus backpressure/reset/throughput sequences.
module tb_wc_tile_buffer;
  import wc_pkg::*;

  localparam int unsigned DW = WC_DW;
  localparam int unsigned TW = WC_DW * WC_TILE;
`ifdef WC_TILE_ZERO_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif
  localparam int unsigned PadTile = PadEn ? 1 : 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          tile_valid;
  logic          tile_ready = 1'b0;
  logic [TW-1:0] tile_data;
  logic          tile_last;

  always #5 clk = ~clk;

  wc_tile_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_data (tile_data),
    .tile_last (tile_last)
  );

  typedef struct {
    logic [TW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int unsigned start;
    int unsigned len;
    int unsigned exp_tiles;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   tile_cnt = 0;
  int   acc_cnt = 0;
  int   first_acc = -1;
  int   last_tile_cyc = 0;

  logic [TW-1:0] hold_data;
  logic          hold_last;
  bit            holding = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] pack_seq(input int first);
    logic [TW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(WC_TILE); i++) v[DW*i +: DW] = DW'(first + i);
    return v;
  endfunction

  // Monitor: scoreboard pops on tile handshakes, stability while stalled, stall/accept counts.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc + 1;
      end
      if (holding) begin
        check("hold_valid", tile_valid, 1);
        check("hold_data", tile_data, hold_data);
        check("hold_last", tile_last, hold_last);
      end
      holding   = tile_valid && !tile_ready;
      hold_data = tile_data;
      hold_last = tile_last;
      if (tile_valid && tile_ready) begin
        tile_cnt++;
        last_tile_cyc = cyc + 1;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tile: got %0h last %0b, expected no tile", tile_data, tile_last);
        end else begin
          e = sb.pop_front();
          check("tile_data", tile_data, e.data);
          check("tile_last", tile_last, e.last);
        end
      end
    end else begin
      holding = 1'b0;
    end
  end

  // Reference tiling of one row: tile k covers samples 3k..3k+4.
  task automatic push_row(input int start, input int len);
    exp_t e;
    int   k;
    int   first_new;
    bit   done;
    k    = 0;
    done = 1'b0;
    while (!done) begin
      first_new = (k == 0) ? 0 : 3 * k + 2;
      if (len <= first_new) begin
        done = 1'b1;
      end else if (3 * k + 5 > len && !PadEn) begin
        done = 1'b1;
      end else begin
        e.data = '0;
        for (int i = 0; i < 5; i++) begin
          if (3 * k + i < len) e.data[DW*i +: DW] = DW'(start + 3 * k + i);
        end
        e.last = (3 * k + 5 >= len);
        sb.push_back(e);
        done = e.last;
        k++;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: sample %0d not accepted, expected in_ready=1", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_row(input int start, input int len);
    for (int i = 0; i < len; i++) send(start + i, i == len - 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || tile_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int t0;
    int s0;
    int a0;

    vecs[0] = '{1, 8, 2};
    vecs[1] = '{1, 6, 1 + PadTile};
    vecs[2] = '{30, 5, 1};
    vecs[3] = '{200, 3, PadTile};
    vecs[4] = '{60, 5, 1};
    vecs[5] = '{300, 14, 4};
    vecs[6] = '{400, 10, 2 + PadTile};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_tile_valid", tile_valid, 0);
    check("rst_tile_data", tile_data, 0);
    check("rst_tile_last", tile_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tile_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Row table
    for (int v = 0; v < 7; v++) begin
      t0 = tile_cnt;
      push_row(int'(vecs[v].start), int'(vecs[v].len));
      send_row(int'(vecs[v].start), int'(vecs[v].len));
      drain($sformatf("row%0d", v));
      check($sformatf("row%0d_tiles", v), tile_cnt - t0, vecs[v].exp_tiles);
    end

    // Backpressure: slot held, input stalls after sample 8
    tile_ready = 1'b0;
    t0 = tile_cnt;
    a0 = acc_cnt;
    push_row(1, 11);
    fork
      send_row(1, 11);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", acc_cnt - a0, 8);
        check("bp_tile_held", tile_data, pack_seq(1));
        check("bp_valid_held", tile_valid, 1);
        @(posedge clk);
        #1;
        tile_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_tiles", tile_cnt - t0, 3);
    check("bp_accepted_total", acc_cnt - a0, 11);

    // Back-to-back rows: exactly one bubble
    s0 = stall_cnt;
    t0 = tile_cnt;
    push_row(1, 5);
    push_row(6, 5);
    send_row(1, 5);
    send_row(6, 5);
    drain("b2b");
    check("b2b_bubbles", stall_cnt - s0, 1);
    check("b2b_tiles", tile_cnt - t0, 2);

    // Reset mid-operation discards window and pending tile
    tile_ready = 1'b0;
    send_row(1, 7);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_in_ready_pre", in_ready, 0);
    @(negedge clk);
    check("mrst_tile_valid", tile_valid, 0);
    check("mrst_in_ready", in_ready, 0);
    rst = 1'b1;
    tile_ready = 1'b1;
    @(posedge clk);
    #1;
    t0 = tile_cnt;
    push_row(20, 5);
    send_row(20, 5);
    drain("mrst");
    check("mrst_tiles", tile_cnt - t0, 1);

    // Throughput: 35-sample row, 11 tiles, no stalls inside the row
    s0 = stall_cnt;
    t0 = tile_cnt;
    first_acc = -1;
    push_row(500, 35);
    send_row(500, 35);
    drain("tput");
    check("tput_stalls", stall_cnt - s0, 0);
    check("tput_tiles", tile_cnt - t0, 11);
    check("tput_cycles", last_tile_cyc - first_acc, 36);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
